// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer transmit arbiter.
// Holds the FSM state encoding, the default preamble byte and the requester count.
package serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'd197;
  localparam int         N_REQ             = 2;

  // Picks requester idx's byte out of the packed request data bus.
  function automatic logic [7:0] byte_of(input logic [8*N_REQ-1:0] bus, input logic idx);
    return idx ? bus[15:8] : bus[7:0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the serializer's parallel load port.
// Each packet is prefixed with a sync byte and followed by a minimum idle gap.
module serdes_tx_arbiter
  import serdes_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               p_clk_i,
  input  logic               prst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_pdata_o,
  output logic               tx_pdata_valid_o,
  input  logic               tx_pdata_ack_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic [15:0]        pkt_cnt_o,
  output state_e             dbg_state_o
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);
  localparam bit         NO_GAP   = (GAP_CYCLES == 0);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               rr_last_q, rr_last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic               ack_seen;
  logic               ready_en;
  logic               xfer;
  logic               sel_idx;
  logic [7:0]         sel_data;
  logic               sel_last;

  rr_arb2 u_rr_arb2 (
    .req_i  (req_valid_i),
    .last_i (rr_last_q),
    .gnt_o  (arb_gnt)
  );

  // Handshakes: a requester byte moves when req_valid_i and req_ready_o are
  // both high on a rising edge; a serializer byte is consumed when
  // tx_pdata_valid_o and tx_pdata_ack_i are both high. An ack without valid
  // is ignored. Valid never drops and data never changes until acked.
  assign ack_seen    = tx_pdata_ack_i & tx_valid_q;
  assign ready_en    = (state_q == ST_DATA) & (~tx_valid_q | tx_pdata_ack_i);
  assign req_ready_o = grant_q & {N_REQ{ready_en}};
  assign xfer        = |(req_valid_i & req_ready_o);

  assign sel_idx  = grant_q[1];
  assign sel_data = byte_of(req_data_i, sel_idx);
  assign sel_last = req_last_i[sel_idx];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pkt_cnt_d  = pkt_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d    = arb_gnt;
          rr_last_d  = arb_gnt[1];
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          state_d    = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (ack_seen) begin
          tx_valid_d = 1'b0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        // A new byte replaces an acked one in the same cycle, keeping valid high.
        if (xfer) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          if (sel_last) begin
            state_d = ST_DRAIN;
          end
        end else if (ack_seen) begin
          tx_valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (ack_seen) begin
          tx_valid_d = 1'b0;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          grant_d    = '0;
          if (NO_GAP) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = GAP_INIT;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // busy tracks the next state so it is registered alongside the state itself.
  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge p_clk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_last_q  <= 1'b1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign tx_pdata_o       = tx_data_q;
  assign tx_pdata_valid_o = tx_valid_q;
  assign grant_o          = grant_q;
  assign busy_o           = busy_q;
  assign pkt_cnt_o        = pkt_cnt_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Directed bench for serdes_tx_arbiter: three instances (gap 2, 3, 0) share stimulus;
// the gap-2 instance is scoreboarded, the others are used for packet-spacing checks.
`timescale 1ns/1ps
module tb_serdes_tx_arbiter;
  import serdes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic        ack       = 1'b0;

  logic [1:0]  ready, ready3, ready0;
  logic [7:0]  tx_data, tx_data3, tx_data0;
  logic        tx_valid, tx_valid3, tx_valid0;
  logic [1:0]  grant, grant3, grant0;
  logic        busy, busy3, busy0;
  logic [15:0] pkt_cnt, pkt_cnt3, pkt_cnt0;
  state_e      state, state3, state0;

  serdes_tx_arbiter #(.GAP_CYCLES(2)) dut (
    .p_clk_i(clk), .prst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready), .tx_pdata_o(tx_data),
    .tx_pdata_valid_o(tx_valid), .tx_pdata_ack_i(ack), .grant_o(grant),
    .busy_o(busy), .pkt_cnt_o(pkt_cnt), .dbg_state_o(state)
  );

  serdes_tx_arbiter #(.GAP_CYCLES(3)) dut3 (
    .p_clk_i(clk), .prst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready3), .tx_pdata_o(tx_data3),
    .tx_pdata_valid_o(tx_valid3), .tx_pdata_ack_i(ack), .grant_o(grant3),
    .busy_o(busy3), .pkt_cnt_o(pkt_cnt3), .dbg_state_o(state3)
  );

  serdes_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
    .p_clk_i(clk), .prst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready0), .tx_pdata_o(tx_data0),
    .tx_pdata_valid_o(tx_valid0), .tx_pdata_ack_i(ack), .grant_o(grant0),
    .busy_o(busy0), .pkt_cnt_o(pkt_cnt0), .dbg_state_o(state0)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [1:0] grant_log[$];

  int   cyc = 0;
  int   ack_delay = 1;
  int   age = 0;
  bit   acked_prev = 1'b0;
  bit   ack_force = 1'b0;
  bit   stall_chk = 1'b0;
  logic [7:0] stall_byte = '0;
  int   last_ack_cyc = 0, drain_ack_cyc = 0, busy_fall_cyc = 0;
  int   rise_m = 0, rise3 = 0, rise0 = 0;
  logic vprev = 1'b0, vprev3 = 1'b0, vprev0 = 1'b0, busy_prev = 1'b0;
  logic [1:0] grant_prev = '0;
  int   t_req, f_ack;

  // ---------------- scoreboard / checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    bit x0, x1, acc;
    logic [7:0] pre_data;
    if (acked_prev) age = 0;
    if (tx_valid) age++; else age = 0;
    ack = ack_force | (tx_valid && (age > ack_delay));
    req_valid[0] = (src_q0.size() > 0);
    req_data[7:0] = req_valid[0] ? src_q0[0][7:0] : 8'h00;
    req_last[0] = req_valid[0] ? src_q0[0][8] : 1'b0;
    req_valid[1] = (src_q1.size() > 0);
    req_data[15:8] = req_valid[1] ? src_q1[0][7:0] : 8'h00;
    req_last[1] = req_valid[1] ? src_q1[0][8] : 1'b0;
    #1;
    if (stall_chk) begin
      check_eq("stall_data", 32'(tx_data), 32'(stall_byte));
      check_eq("stall_ready", 32'(ready), 32'd0);
    end
    x0 = req_valid[0] & ready[0];
    x1 = req_valid[1] & ready[1];
    acc = ack & tx_valid;
    pre_data = tx_data;
    if (acc) begin
      last_ack_cyc = cyc;
      if (state == ST_DRAIN) drain_ack_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
    acked_prev = acc;
    if (x0) void'(src_q0.pop_front());
    if (x1) void'(src_q1.pop_front());
    if (acc) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
      else check_eq("sb_byte", 32'(pre_data), 32'(exp_q.pop_front()));
    end
    if (tx_valid && !vprev && tx_data == SYNC_BYTE_DEFAULT && rise_m < 0) rise_m = cyc;
    if (tx_valid3 && !vprev3 && tx_data3 == SYNC_BYTE_DEFAULT && rise3 < 0) rise3 = cyc;
    if (tx_valid0 && !vprev0 && tx_data0 == SYNC_BYTE_DEFAULT && rise0 < 0) rise0 = cyc;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    if (grant != grant_prev) grant_log.push_back(grant);
    vprev = tx_valid; vprev3 = tx_valid3; vprev0 = tx_valid0;
    busy_prev = busy; grant_prev = grant;
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      cycle();
      done = (exp_q.size() == 0) && (src_q0.size() == 0) && (src_q1.size() == 0) &&
             (state == ST_IDLE) && !busy;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic reset_dut();
    ack_force = 1'b0; age = 0; acked_prev = 1'b0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data"}, 32'(tx_data), 32'd0);
    check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready), 32'd0);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_pkt"}, 32'(pkt_cnt), 32'd0);
    check_eq({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Contention: both requesters hold a packet from reset.
    src_q0.push_back(9'h0C1); src_q0.push_back(9'h1C2);
    src_q1.push_back(9'h0D1); src_q1.push_back(9'h1D2);
    rst_n = 1'b0;
    cycle();
    cycle();
    check_reset_vals("reset");
    rst_n = 1'b1;
    exp_q = '{8'd197, 8'hC1, 8'hC2, 8'd197, 8'hD1, 8'hD2};
    run_until_idle("contend", 100);
    check_eq("contend_pkt", 32'(pkt_cnt), 32'd2);
    check_eq("contend_log_len", 32'(grant_log.size() >= 3), 32'd1);
    if (grant_log.size() >= 3) begin
      check_eq("contend_grant0", 32'(grant_log[0]), 32'h1);
      check_eq("contend_grant1", 32'(grant_log[1]), 32'h0);
      check_eq("contend_grant2", 32'(grant_log[2]), 32'h2);
    end

    // Single packet, ack one cycle after each valid.
    rise_m = -1;
    t_req = cyc;
    src_q0.push_back(9'h011); src_q0.push_back(9'h022); src_q0.push_back(9'h133);
    exp_q = '{8'd197, 8'h11, 8'h22, 8'h33};
    run_until_idle("single", 60);
    check_eq("single_latency", 32'(rise_m - t_req), 32'd1);
    check_eq("single_busy_fall", 32'(busy_fall_cyc - last_ack_cyc), 32'd3);
    check_eq("single_pkt", 32'(pkt_cnt), 32'd3);

    // Ack stall of 5 cycles on the first data byte.
    src_q1.push_back(9'h0A1); src_q1.push_back(9'h1A2);
    exp_q = '{8'd197, 8'hA1, 8'hA2};
    for (int i = 0; i < 30 && !(tx_valid && tx_data == 8'hA1); i++) cycle();
    check_eq("stall_reach", 32'(tx_valid && tx_data == 8'hA1), 32'd1);
    ack_delay = 5;
    stall_byte = 8'hA1;
    stall_chk = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    stall_chk = 1'b0;
    cycle();
    ack_delay = 1;
    run_until_idle("stall", 60);
    check_eq("stall_pkt", 32'(pkt_cnt), 32'd4);

    // Spurious ack in IDLE.
    ack_force = 1'b1;
    cycle();
    ack_force = 1'b0;
    check_eq("spur_idle_state", 32'(state), 32'(ST_IDLE));
    check_eq("spur_idle_valid", 32'(tx_valid), 32'd0);
    check_eq("spur_idle_pkt", 32'(pkt_cnt), 32'd4);

    // Single-byte packet, then a spurious ack inside GAP.
    src_q0.push_back(9'h15A);
    exp_q = '{8'd197, 8'h5A};
    for (int i = 0; i < 30 && state != ST_GAP; i++) cycle();
    check_eq("spur_gap_reach", 32'(state), 32'(ST_GAP));
    ack_force = 1'b1;
    cycle();
    ack_force = 1'b0;
    check_eq("spur_gap_state", 32'(state), 32'(ST_GAP));
    check_eq("spur_gap_pkt", 32'(pkt_cnt), 32'd5);
    cycle();
    check_eq("spur_gap_exit", 32'(state), 32'(ST_IDLE));
    check_eq("spur_gap_pkt2", 32'(pkt_cnt), 32'd5);
    check_eq("spur_gap_sb", 32'(exp_q.size()), 32'd0);

    // Gap enforcement across GAP_CYCLES = 2, 3 and 0, req1 raised during DRAIN.
    reset_dut();
    rise_m = 0; rise3 = 0; rise0 = 0;
    src_q0.push_back(9'h071); src_q0.push_back(9'h172);
    exp_q = '{8'd197, 8'h71, 8'h72, 8'd197, 8'h81};
    for (int i = 0; i < 40 && state != ST_DRAIN; i++) cycle();
    check_eq("gap_reach_drain", 32'(state), 32'(ST_DRAIN));
    rise_m = -1; rise3 = -1; rise0 = -1;
    src_q1.push_back(9'h181);
    for (int i = 0; i < 20 && state == ST_DRAIN; i++) cycle();
    f_ack = drain_ack_cyc;
    run_until_idle("gap", 80);
    check_eq("gap2_spacing", 32'(rise_m - f_ack), 32'd4);
    check_eq("gap3_spacing", 32'(rise3 - f_ack), 32'd5);
    check_eq("gap0_spacing", 32'(rise0 - f_ack), 32'd2);

    // Reset asserted mid-packet while a data byte is in flight.
    reset_dut();
    src_q0.push_back(9'h091); src_q0.push_back(9'h092); src_q0.push_back(9'h193);
    exp_q = '{8'd197, 8'h91};
    for (int i = 0; i < 30 && !(state == ST_DATA && tx_valid && tx_data == 8'h91); i++) cycle();
    check_eq("rst_reach", 32'(state == ST_DATA && tx_valid && tx_data == 8'h91), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    exp_q.delete();
    src_q0.delete();
    ack = 1'b0; age = 0; acked_prev = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    src_q0.push_back(9'h091); src_q0.push_back(9'h092); src_q0.push_back(9'h193);
    exp_q = '{8'd197, 8'h91, 8'h92, 8'h93};
    run_until_idle("rst_resend", 60);
    check_eq("rst_resend_pkt", 32'(pkt_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serdes_tx_arbiter.md
# serdes_tx_arbiter

Packet-level round-robin arbiter that shares the serializer's single parallel load port (`tx_pdata_o` / `tx_pdata_valid_o`) between two byte-stream requesters in the `p_clk_i` domain. Each granted packet is prefixed with a sync byte, held until the serializer acknowledges each byte, and followed by a minimum idle gap before the next grant. It sits between the requester logic and the serializer's parallel input register.

## Interface
- `SYNC_BYTE`, 8'd197 — preamble byte sent before every packet
- `GAP_CYCLES`, 2 — minimum idle `p_clk_i` cycles between the last ack of a packet and the next grant; 0..15
- `p_clk_i` in 1 — parallel clock; the block's only clock
- `prst_n_i` in 1 — reset, asynchronous assert, active-low
- `req_valid_i` in 2 — per-requester byte valid
- `req_data_i` in 2x8 — per-requester byte; `[7:0]` is requester 0, `[15:8]` is requester 1
- `req_last_i` in 2 — marks the final byte of a packet
- `req_ready_o` out 2 — byte accepted when valid and ready are both high
- `tx_pdata_o` out 8 — byte presented to the serializer
- `tx_pdata_valid_o` out 1 — `tx_pdata_o` is valid; held stable until acked
- `tx_pdata_ack_i` in 1 — serializer loaded the byte; one-cycle pulse, already synchronous to `p_clk_i`
- `grant_o` out 2 — one-hot owner of the current packet; 0 when idle
- `busy_o` out 1 — state ≠ IDLE
- `pkt_cnt_o` out 16 — count of completed packets, wraps

## Operation
- **States:** IDLE, SYNC, DATA, DRAIN, GAP.
- **IDLE:**
  - If any `req_valid_i` is high, grant on the next edge.
  - If both are high, grant the requester not granted last. `rr_last` resets to 1, so requester 0 wins first.
  - On the grant edge:
    - `grant_o` is set and `rr_last` updates.
    - `tx_pdata_o` loads `SYNC_BYTE` with `tx_pdata_valid_o` set to 1.
    - State moves to SYNC.
- **SYNC:** on `tx_pdata_ack_i`, valid is cleared and state moves to DATA.
- **DATA:**
  - `req_ready_o[g] = grant_o[g] & (!tx_pdata_valid_o | tx_pdata_ack_i)`. The non-granted ready stays 0.
  - On a transfer, `tx_pdata_o` loads the byte and valid is set to 1.
  - On an ack with no transfer, valid is cleared.
  - A transfer with `req_last_i` moves state to DRAIN.
- **DRAIN:** on ack, valid is cleared and `pkt_cnt_o` increments.
  - If `GAP_CYCLES` is 0, go to IDLE.
  - Otherwise load the gap counter with `GAP_CYCLES` and go to GAP.
- **GAP:** decrement each cycle; leave for IDLE on the cycle the counter equals 1. `grant_o` clears on DRAIN exit.
- **Boundary conditions:**
  - `tx_pdata_ack_i` while valid is 0 is ignored.
  - A requester dropping valid mid-packet stalls DATA indefinitely; there is no timeout and the grant is kept.
  - A request arriving during GAP waits for IDLE.
  - A single-byte packet (last on the first byte) is legal: SYNC, then 1 byte, then DRAIN.
  - Reset mid-packet clears all state and drops the byte in flight. Requesters must resend the whole packet.
- **Reset values:**
  - `tx_pdata_o` = 0
  - `tx_pdata_valid_o` = 0
  - `req_ready_o` = 0
  - `grant_o` = 0
  - `busy_o` = 0
  - `pkt_cnt_o` = 0
  - State = IDLE

## Timing
- All outputs are registered except `req_ready_o`, which is combinational from state, valid, and ack.
- Grant latency: `req_valid_i` high in cycle t gives `tx_pdata_valid_o` = 1 with `SYNC_BYTE` in cycle t+1.
- After the SYNC ack there is one bubble cycle; the first data byte can be valid at the earliest 2 cycles after the SYNC ack cycle.
- Steady state with ack in the cycle after each valid: 1 byte per 2 cycles.
- Back-to-back: an ack and a new transfer in the same cycle keep valid high with the new byte.
- Packet spacing: the next SYNC valid appears no earlier than `GAP_CYCLES` + 2 cycles after the final ack.

## Structure
- Package `serdes_pkg`:
  - State enum
  - Default `SYNC_BYTE` constant (8'd197)
  - Requester count constant (2)
- Sub-module `rr_arb2`: 2-way round-robin pick from request and last-grant inputs, giving a one-hot grant. Combinational; `rr_last` is held in the parent.

## Test plan
- **Single packet:** req0 sends 3 bytes (`last` on 8'h33) with ack 1 cycle after each valid. The serializer sees 8'd197, 11, 22, 33; `pkt_cnt_o` = 1; `busy_o` falls `GAP_CYCLES` + 1 cycles after the last ack.
- **Contention:** both requesters are valid from reset. Requester 0 is granted first and requester 1 second, with no interleaving inside a packet; `grant_o` goes 01 → 00 → 10.
- **Ack stall:** ack is delayed 5 cycles on a data byte. `tx_pdata_o` stays stable and `req_ready_o` stays 0 for those 5 cycles.
- **Gap enforcement:** with `GAP_CYCLES` = 3 and req1 asserted during DRAIN, the next SYNC valid appears exactly 5 cycles after the final ack. With `GAP_CYCLES` = 0, it appears exactly 2 cycles after.
- **Reset mid-packet:** assert `prst_n_i` low during DATA. All outputs go to reset values immediately (asynchronously), `pkt_cnt_o` = 0, and the next packet starts with `SYNC_BYTE`.
- **Spurious ack:** ack pulses while in IDLE and GAP produce no state change and no count change.
